// File: rtl/arr_cnts_framer_if.sv
// ---------------------------------------------------------------------------
// arr_cnts_framer_if
// Write-side bundle between the counter-array framer and the readout FIFO.
//   fifo_wr_o          framer -> FIFO   write strobe
//   fifo_data_o        framer -> FIFO   32-bit write data
//   fifo_full_i        FIFO -> framer   FIFO full
//   fifo_almst_full_i  FIFO -> framer   FIFO almost full
// master = framer side, slave = FIFO side.
// ---------------------------------------------------------------------------
interface arr_cnts_framer_if;
  logic        fifo_wr_o;
  logic [31:0] fifo_data_o;
  logic        fifo_full_i;
  logic        fifo_almst_full_i;

  modport master (
    output fifo_wr_o,
    output fifo_data_o,
    input  fifo_full_i,
    input  fifo_almst_full_i
  );

  modport slave (
    input  fifo_wr_o,
    input  fifo_data_o,
    output fifo_full_i,
    output fifo_almst_full_i
  );
endinterface

// File: rtl/arr_cnts_framer.sv
// ---------------------------------------------------------------------------
// arr_cnts_framer
// Snapshots a NUM_WORDS x 32-bit counter array and streams it into a 32-bit
// FIFO as one frame: header {HDR_TAG, 8'h00, seq}, data words (word 0 first),
// footer {FTR_TAG, 8'h00, xor-checksum}. Continuous or triggered acquisition,
// FIFO backpressure via full/almost-full, and trigger-drop reporting.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   en_i          acquisition enable (sampled in IDLE)
//   mode_i        0 = continuous, 1 = triggered (sampled in IDLE)
//   trig_i        trigger pulse (triggered mode only)
//   data_i        counter array, word k = data_i[32k+31:32k]
//   fifo          FIFO write interface (master modport)
//   busy_o        high whenever not IDLE
//   frame_done_o  one-cycle pulse after the footer is accepted
//   trig_drop_o   one-cycle pulse when a trigger is lost
//   frame_seq_o   sequence number of the next frame
// ---------------------------------------------------------------------------
module arr_cnts_framer #(
  parameter int unsigned NUM_WORDS = 256,
  parameter logic [7:0]  HDR_TAG   = 8'hAA,
  parameter logic [7:0]  FTR_TAG   = 8'hFF
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   mode_i,
  input  logic                   trig_i,
  input  logic [NUM_WORDS*32-1:0] data_i,
  arr_cnts_framer_if.master      fifo,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic                   trig_drop_o,
  output logic [15:0]            frame_seq_o
);

  localparam int unsigned     IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR,
    ST_DATA,
    ST_FTR
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       chk_q, chk_d;
  logic [15:0]       seq_q, seq_d;
  logic              trig_pend_q, trig_pend_d;
  logic              mode_q, mode_d;
  logic              frame_done_q, frame_done_d;
  logic              trig_drop_q, trig_drop_d;
  logic [31:0]       shadow_q [NUM_WORDS];
  logic [31:0]       shadow_d [NUM_WORDS];

  logic              accept;
  logic              start;
  logic [31:0]       cur_word;

  assign cur_word = shadow_q[idx_q];

  // A pending trigger or a trigger arriving in IDLE both start a frame in
  // triggered mode; continuous mode only needs the enable.
  assign start = en_i & (~mode_i | trig_pend_q | trig_i);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HDR/DATA/FTR advance only on an accepted write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_HDR;
      ST_HDR:  if (accept) state_d = ST_DATA;
      ST_DATA: if (accept && (idx_q == LAST_IDX)) state_d = ST_FTR;
      ST_FTR:  if (accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; the current word is shown even when the write is stalled
  always_comb begin
    accept            = 1'b0;
    fifo.fifo_data_o  = 32'h0;
    unique case (state_q)
      ST_HDR: begin
        accept           = ~fifo.fifo_almst_full_i & ~fifo.fifo_full_i;
        fifo.fifo_data_o = {HDR_TAG, 8'h00, seq_q};
      end
      ST_DATA: begin
        accept           = ~fifo.fifo_almst_full_i & ~fifo.fifo_full_i;
        fifo.fifo_data_o = cur_word;
      end
      ST_FTR: begin
        accept           = ~fifo.fifo_almst_full_i & ~fifo.fifo_full_i;
        fifo.fifo_data_o = {FTR_TAG, 8'h00, chk_q};
      end
      default: begin
        accept           = 1'b0;
        fifo.fifo_data_o = 32'h0;
      end
    endcase
    fifo.fifo_wr_o = accept;
    busy_o         = (state_q != ST_IDLE);
  end

  // Datapath next values: index, checksum, sequence, trigger bookkeeping.
  // Mode is latched on leaving IDLE so a mid-frame mode change is ignored.
  // A trigger arriving during LOAD belongs to the next frame, so it re-arms
  // the pending flag instead of being lost.
  always_comb begin
    idx_d        = idx_q;
    chk_d        = chk_q;
    seq_d        = seq_q;
    mode_d       = mode_q;
    trig_pend_d  = trig_pend_q;
    frame_done_d = 1'b0;
    trig_drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: mode_d = mode_i;
      ST_LOAD: begin
        idx_d = '0;
        chk_d = 16'h0;
      end
      ST_DATA: begin
        if (accept) begin
          idx_d = idx_q + 1'b1;
          chk_d = chk_q ^ cur_word[31:16] ^ cur_word[15:0];
        end
      end
      ST_FTR: begin
        if (accept) begin
          seq_d        = seq_q + 16'd1;
          frame_done_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_q == ST_LOAD) begin
      trig_pend_d = mode_q & trig_i;
    end else if ((state_q != ST_IDLE) && mode_q && trig_i) begin
      if (trig_pend_q) begin
        trig_drop_d = 1'b1;
      end else begin
        trig_pend_d = 1'b1;
      end
    end
  end

  // Snapshot is taken in LOAD only; the frame is immune to later data_i changes
  always_comb begin
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      shadow_d[k] = (state_q == ST_LOAD) ? data_i[32*k +: 32] : shadow_q[k];
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q        <= '0;
      chk_q        <= 16'h0;
      seq_q        <= 16'h0;
      mode_q       <= 1'b0;
      trig_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      trig_drop_q  <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      seq_q        <= seq_d;
      mode_q       <= mode_d;
      trig_pend_q  <= trig_pend_d;
      frame_done_q <= frame_done_d;
      trig_drop_q  <= trig_drop_d;
    end
  end

  // Shadow storage needs no reset: it is always reloaded before use
  always_ff @(posedge clk_i) begin
    shadow_q <= shadow_d;
  end

  assign frame_done_o = frame_done_q;
  assign trig_drop_o  = trig_drop_q;
  assign frame_seq_o  = seq_q;

endmodule

// File: tb/tb_arr_cnts_framer.sv
// ---------------------------------------------------------------------------
// tb_arr_cnts_framer
// Self-checking bench for arr_cnts_framer with NUM_WORDS = 4. Expected FIFO
// words are queued when a frame is launched and popped by a monitor on each
// write strobe; timing, stalls, triggers and reset are checked directly.
// ---------------------------------------------------------------------------
module tb_arr_cnts_framer;
  localparam int NW = 4;

  typedef logic [31:0] words_t [NW];

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            mode;
  logic            trig;
  logic [NW*32-1:0] data;
  logic            busy;
  logic            frame_done;
  logic            trig_drop;
  logic [15:0]     frame_seq;

  int              n_compared   = 0;
  int              n_mismatched = 0;
  int              cyc          = 0;
  int              c0;
  int              dc;
  logic [31:0]     sb_q [$];
  int              wr_cyc [$];

  words_t w_inc  = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
  words_t w_bp   = '{32'h11110000, 32'h00002222, 32'h33334444, 32'hDEADBEEF};
  words_t w_trg  = '{32'hA5A50001, 32'h5A5A0002, 32'h0F0F00F0, 32'h12345678};
  words_t w_five = '{32'h00000005, 32'h00000005, 32'h00000005, 32'h00000005};
  words_t w_nine = '{32'h00000009, 32'h00000009, 32'h00000009, 32'h00000009};

  arr_cnts_framer_if fifo_if ();

  arr_cnts_framer #(
    .NUM_WORDS (NW),
    .HDR_TAG   (8'hAA),
    .FTR_TAG   (8'hFF)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .mode_i       (mode),
    .trig_i       (trig),
    .data_i       (data),
    .fifo         (fifo_if.master),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .trig_drop_o  (trig_drop),
    .frame_seq_o  (frame_seq)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic m, input logic t,
                               input logic af, input logic f);
    en                       = e;
    mode                     = m;
    trig                     = t;
    fifo_if.fifo_almst_full_i = af;
    fifo_if.fifo_full_i       = f;
  endtask

  task automatic setData(input words_t w);
    for (int k = 0; k < NW; k++) data[32*k +: 32] = w[k];
  endtask

  // Reference frame: header, words, footer with the folded xor checksum
  task automatic pushFrame(input logic [15:0] seq, input words_t w);
    logic [15:0] chk;
    chk = 16'h0;
    sb_q.push_back({8'hAA, 8'h00, seq});
    for (int k = 0; k < NW; k++) begin
      sb_q.push_back(w[k]);
      chk = chk ^ w[k][31:16] ^ w[k][15:0];
    end
    sb_q.push_back({8'hFF, 8'h00, chk});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int max_cyc, input string tag, output int at_cyc);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(frame_done), 32'd1);
    at_cyc = cyc;
  endtask

  // Scoreboard monitor: every write strobe must match the next queued word
  always @(negedge clk) begin
    if (fifo_if.fifo_wr_o === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_write", fifo_if.fifo_data_o, 32'hFFFFFFFF ^ fifo_if.fifo_data_o);
      end else begin
        checkOutput("fifo_data", fifo_if.fifo_data_o, sb_q.pop_front());
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    data  = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    checkOutput("reset_wr",   32'(fifo_if.fifo_wr_o), 32'd0);
    checkOutput("reset_data", fifo_if.fifo_data_o,    32'h0);
    checkOutput("reset_busy", 32'(busy),              32'd0);
    checkOutput("reset_done", 32'(frame_done),        32'd0);
    checkOutput("reset_drop", 32'(trig_drop),         32'd0);
    checkOutput("reset_seq",  32'(frame_seq),         32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Continuous mode, two back-to-back frames
    $display("[TB] continuous mode");
    setData(w_inc);
    pushFrame(16'd0, w_inc);
    pushFrame(16'd1, w_inc);
    wr_cyc.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    waitDone(30, "cont_done0", dc);
    checkOutput("cont_done0_cyc", 32'(dc - c0), 32'(NW + 4));
    checkOutput("cont_seq_after0", 32'(frame_seq), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDone(30, "cont_done1", dc);
    checkOutput("cont_done1_cyc", 32'(dc - c0), 32'(2 * (NW + 4)));
    repeat (3) tick();
    checkOutput("cont_idle_busy", 32'(busy), 32'd0);
    checkOutput("cont_sb_empty", 32'(sb_q.size()), 32'd0);
    checkOutput("cont_nwrites", 32'(wr_cyc.size()), 32'd12);
    if (wr_cyc.size() == 12) begin
      checkOutput("cont_hdr_cyc",    32'(wr_cyc[0] - c0), 32'd2);
      checkOutput("cont_ftr_cyc",    32'(wr_cyc[5] - c0), 32'(NW + 3));
      checkOutput("cont_period_cyc", 32'(wr_cyc[6] - wr_cyc[0]), 32'(NW + 4));
    end

    // Almost-full for three cycles while data word 2 is presented
    $display("[TB] backpressure");
    setData(w_bp);
    pushFrame(16'd2, w_bp);
    wr_cyc.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_wr_low_%0d", i), 32'(fifo_if.fifo_wr_o), 32'd0);
      checkOutput($sformatf("bp_hold_%0d", i), fifo_if.fifo_data_o, w_bp[2]);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDone(30, "bp_done", dc);
    checkOutput("bp_done_cyc", 32'(dc - c0), 32'(NW + 4 + 3));
    checkOutput("bp_nwrites", 32'(wr_cyc.size()), 32'(NW + 2));
    if (wr_cyc.size() == NW + 2) begin
      checkOutput("bp_word2_cyc", 32'(wr_cyc[3] - c0), 32'd8);
      checkOutput("bp_ftr_cyc",   32'(wr_cyc[5] - c0), 32'(NW + 3 + 3));
    end
    checkOutput("bp_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();

    // Triggered mode: start trigger, then three pulses in one frame
    $display("[TB] triggered mode");
    setData(w_trg);
    pushFrame(16'd3, w_trg);
    pushFrame(16'd4, w_trg);
    wr_cyc.delete();
    c0 = cyc;
    for (int k = 0; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b1, (k == 0 || k == 3 || k == 5 || k == 7), 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("trig_drop_%0d", k), 32'(trig_drop), 32'((k == 6) || (k == 8)));
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    waitDone(30, "trig_done", dc);
    checkOutput("trig_done_cyc", 32'(dc - c0), 32'(2 * (NW + 4)));
    if (wr_cyc.size() >= NW + 3) begin
      checkOutput("trig_extra_hdr_cyc", 32'(wr_cyc[NW + 2] - c0), 32'(NW + 4 + 2));
    end
    repeat (4) tick();
    checkOutput("trig_no_third_frame", 32'(busy), 32'd0);
    checkOutput("trig_sb_empty", 32'(sb_q.size()), 32'd0);
    checkOutput("trig_seq", 32'(frame_seq), 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Snapshot isolation; triggers ignored in continuous mode
    $display("[TB] snapshot isolation");
    setData(w_five);
    pushFrame(16'd5, w_five);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    setData(w_nine);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("cont_trig_ignored", 32'(trig_drop), 32'd0);
    waitDone(30, "snap_done", dc);
    checkOutput("snap_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();

    // Asynchronous reset while DATA is streaming
    $display("[TB] reset mid-frame");
    setData(w_inc);
    sb_q.push_back(32'hAA000006);
    sb_q.push_back(w_inc[0]);
    sb_q.push_back(w_inc[1]);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_drop", 32'(fifo_if.fifo_wr_o), 32'd0);
    checkOutput("rst_data",    fifo_if.fifo_data_o,    32'h0);
    checkOutput("rst_busy",    32'(busy),              32'd0);
    checkOutput("rst_seq",     32'(frame_seq),         32'd0);
    tick();
    checkOutput("rst_partial_sb", 32'(sb_q.size()), 32'd0);
    rst_n = 1'b1;
    tick();
    pushFrame(16'd0, w_inc);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDone(30, "rst_restart_done", dc);
    checkOutput("rst_restart_seq", 32'(frame_seq), 32'd1);
    checkOutput("rst_sb_empty", 32'(sb_q.size()), 32'd0);
    tick();

    // Sequence wrap, with a one-cycle FIFO-full stall on the header
    $display("[TB] sequence wrap");
    force dut.seq_q = 16'hFFFF;
    tick();
    release dut.seq_q;
    #1;
    checkOutput("wrap_preload", 32'(frame_seq), 32'h0000FFFF);
    pushFrame(16'hFFFF, w_inc);
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("full_wr_low", 32'(fifo_if.fifo_wr_o), 32'd0);
    checkOutput("full_hdr_held", fifo_if.fifo_data_o, 32'hAA00FFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDone(30, "wrap_done", dc);
    checkOutput("wrap_done_cyc", 32'(dc - c0), 32'(NW + 5));
    checkOutput("wrap_seq", 32'(frame_seq), 32'd0);
    checkOutput("wrap_sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
